pcie_us_cq_reg_completer: RTL and testbench

Target-side completer that sits directly downstream of the UltraScale PCIe core's completer request (CQ) interface and upstream of its completer completion (CC) interface. Parses 64-bit CQ descriptors and executes single-DW BAR0 memory reads and writes against an external register port. Returns CC completions (SC or UR). Gives the core non-posted credit through pcie_cq_np_req.

---
 rtl/pcie_us_cq_reg_completer_if.sv | 47 ++++
 rtl/pcie_us_cq_reg_completer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_pcie_us_cq_reg_completer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_us_cq_reg_completer_if.sv
// CQ request and CC completion streams between the UltraScale PCIe core and the
// BAR0 register completer. The master modport is the core's view, slave the completer's.
interface pcie_us_cq_reg_completer_if;
    logic [63:0] s_axis_cq_tdata;
    logic [1:0]  s_axis_cq_tkeep;
    logic        s_axis_cq_tlast;
    logic [84:0] s_axis_cq_tuser;
    logic        s_axis_cq_tvalid;
    logic        s_axis_cq_tready;

    logic [63:0] m_axis_cc_tdata;
    logic [1:0]  m_axis_cc_tkeep;
    logic        m_axis_cc_tlast;
    logic [32:0] m_axis_cc_tuser;
    logic        m_axis_cc_tvalid;
    logic        m_axis_cc_tready;

    modport master (
        output s_axis_cq_tdata,
        output s_axis_cq_tkeep,
        output s_axis_cq_tlast,
        output s_axis_cq_tuser,
        output s_axis_cq_tvalid,
        input  s_axis_cq_tready,
        input  m_axis_cc_tdata,
        input  m_axis_cc_tkeep,
        input  m_axis_cc_tlast,
        input  m_axis_cc_tuser,
        input  m_axis_cc_tvalid,
        output m_axis_cc_tready
    );

    modport slave (
        input  s_axis_cq_tdata,
        input  s_axis_cq_tkeep,
        input  s_axis_cq_tlast,
        input  s_axis_cq_tuser,
        input  s_axis_cq_tvalid,
        output s_axis_cq_tready,
        output m_axis_cc_tdata,
        output m_axis_cc_tkeep,
        output m_axis_cc_tlast,
        output m_axis_cc_tuser,
        output m_axis_cc_tvalid,
        input  m_axis_cc_tready
    );
endinterface

// File: rtl/pcie_us_cq_reg_completer.sv
// Single-DW BAR0 register completer for the UltraScale PCIe CQ/CC interfaces.
// Parses 64-bit CQ descriptors, performs register reads/writes and returns SC/UR completions.
// Optional feature macro: CQ_STATS_EN adds saturating read/write/UR statistics counters.
module pcie_us_cq_reg_completer #(
    parameter int unsigned REG_ADDR_WIDTH = 8,
    parameter int unsigned BAR_ID         = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pcie_us_cq_reg_completer_if.slave axis,
    output logic                      pcie_cq_np_req,
    output logic                      reg_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [31:0]               reg_wr_data,
    output logic [3:0]                reg_wr_strb,
    output logic                      reg_rd_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [31:0]               reg_rd_data
`ifdef CQ_STATS_EN
    ,
    output logic [15:0]               stat_rd_count,
    output logic [15:0]               stat_wr_count,
    output logic [15:0]               stat_ur_count
`endif
);

    localparam logic [2:0] BarIdVal  = 3'(BAR_ID);
    localparam logic [3:0] TypeMemRd = 4'b0000;
    localparam logic [3:0] TypeMemWr = 4'b0001;
    localparam logic [3:0] TypeNpMax = 4'b1011;
    localparam logic [2:0] StatusSc  = 3'b000;
    localparam logic [2:0] StatusUr  = 3'b001;

    typedef enum logic [2:0] {
        StIdle,
        StDesc,
        StWdata,
        StRdIssue,
        StRdWait,
        StCpl0,
        StCpl1,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [63:2]               addr_q;
    logic [3:0]                first_be_q;
    logic [15:0]               req_id_q;
    logic [7:0]                tag_q;
    logic [2:0]                tc_q;
    logic [2:0]                attr_q;
    logic [2:0]                status_q;
    logic                      hit_q;
    logic [31:0]               rd_data_q;
    logic                      cq_ready_q, cq_ready_d;
    logic                      wr_en_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]               wr_data_q;
    logic [3:0]                wr_strb_q;

    // Fields of the second CQ beat, i.e. descriptor bits 127:64.
    logic [10:0] desc_dw_count;
    logic [3:0]  desc_type;
    logic [15:0] desc_req_id;
    logic [7:0]  desc_tag;
    logic [2:0]  desc_bar;
    logic [2:0]  desc_tc;
    logic [2:0]  desc_attr;

    assign desc_dw_count = axis.s_axis_cq_tdata[10:0];
    assign desc_type     = axis.s_axis_cq_tdata[14:11];
    assign desc_req_id   = axis.s_axis_cq_tdata[31:16];
    assign desc_tag      = axis.s_axis_cq_tdata[39:32];
    assign desc_bar      = axis.s_axis_cq_tdata[50:48];
    assign desc_tc       = axis.s_axis_cq_tdata[59:57];
    assign desc_attr     = axis.s_axis_cq_tdata[62:60];

    logic       cq_fire;
    logic       cc_valid;
    logic       cc_fire;
    logic       win_ok;
    logic       desc_hit;
    logic       desc_np;
    logic [2:0] desc_status;
    logic       load_addr;
    logic       load_desc;
    logic       load_rdata;
    logic       wr_fire;
    logic [1:0] be_low;
    logic [6:0] lower_addr;

    assign cq_fire  = axis.s_axis_cq_tvalid & cq_ready_q;
    assign cc_valid = (state_q == StCpl0) || (state_q == StCpl1);
    assign cc_fire  = cc_valid & axis.m_axis_cc_tready;

    // Only the decoded register window may carry nonzero address bits.
    assign win_ok      = (addr_q[63:REG_ADDR_WIDTH+2] == '0);
    assign desc_hit    = (desc_bar == BarIdVal) && (desc_dw_count == 11'd1) && win_ok;
    assign desc_np     = (desc_type != TypeMemWr) && (desc_type <= TypeNpMax);
    assign desc_status = ((desc_type == TypeMemRd) && desc_hit) ? StatusSc : StatusUr;

    // Byte offset of the first enabled byte within the dword.
    always_comb begin
        be_low = 2'd0;
        if (first_be_q[0])      be_low = 2'd0;
        else if (first_be_q[1]) be_low = 2'd1;
        else if (first_be_q[2]) be_low = 2'd2;
        else if (first_be_q[3]) be_low = 2'd3;
    end

    assign lower_addr = {addr_q[6:2], be_low};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath load strobes.
    always_comb begin
        state_d    = state_q;
        load_addr  = 1'b0;
        load_desc  = 1'b0;
        load_rdata = 1'b0;
        wr_fire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cq_fire) begin
                    load_addr = 1'b1;
                    // A single-beat TLP cannot hold a descriptor; drop it.
                    state_d   = axis.s_axis_cq_tlast ? StIdle : StDesc;
                end
            end
            StDesc: begin
                if (cq_fire) begin
                    load_desc = 1'b1;
                    if (desc_type == TypeMemRd) begin
                        if (!axis.s_axis_cq_tlast) state_d = StDrop;
                        else if (desc_hit)         state_d = StRdIssue;
                        else                       state_d = StCpl0;
                    end else if (desc_type == TypeMemWr) begin
                        state_d = axis.s_axis_cq_tlast ? StIdle : StWdata;
                    end else if (!axis.s_axis_cq_tlast) begin
                        state_d = StDrop;
                    end else begin
                        state_d = desc_np ? StCpl0 : StIdle;
                    end
                end
            end
            StWdata: begin
                if (cq_fire) begin
                    if (axis.s_axis_cq_tlast) begin
                        wr_fire = hit_q;
                        state_d = StIdle;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                load_rdata = 1'b1;
                state_d    = StCpl0;
            end
            StCpl0: begin
                if (cc_fire) state_d = StCpl1;
            end
            StCpl1: begin
                if (cc_fire) state_d = StIdle;
            end
            StDrop: begin
                if (cq_fire && axis.s_axis_cq_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        cq_ready_d = (state_d == StIdle) || (state_d == StDesc) ||
                     (state_d == StWdata) || (state_d == StDrop);
    end

    // Request fields, read data, write port and registered CQ ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            first_be_q <= '0;
            req_id_q   <= '0;
            tag_q      <= '0;
            tc_q       <= '0;
            attr_q     <= '0;
            status_q   <= '0;
            hit_q      <= 1'b0;
            rd_data_q  <= '0;
            cq_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            if (load_addr) begin
                addr_q     <= axis.s_axis_cq_tdata[63:2];
                first_be_q <= axis.s_axis_cq_tuser[3:0];
            end
            if (load_desc) begin
                req_id_q <= desc_req_id;
                tag_q    <= desc_tag;
                tc_q     <= desc_tc;
                attr_q   <= desc_attr;
                status_q <= desc_status;
                hit_q    <= desc_hit;
            end
            if (load_rdata) begin
                rd_data_q <= reg_rd_data;
            end
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= addr_q[REG_ADDR_WIDTH+1:2];
                wr_data_q <= axis.s_axis_cq_tdata[31:0];
                wr_strb_q <= first_be_q;
            end
            cq_ready_q <= cq_ready_d;
        end
    end

    logic [63:0] cc_tdata;
    logic [1:0]  cc_tkeep;
    logic        cc_tlast;
    logic [10:0] cpl_dw_count;
    logic        cpl_sc;

    assign cpl_sc       = (status_q == StatusSc);
    assign cpl_dw_count = cpl_sc ? 11'd1 : 11'd0;

    // CC beat formatting: beat 0 is DW0/DW1, beat 1 is DW2 plus read data.
    always_comb begin
        cc_tdata = '0;
        cc_tkeep = '0;
        cc_tlast = 1'b0;
        case (state_q)
            StCpl0: begin
                cc_tkeep = 2'b11;
                cc_tdata = {req_id_q, 2'b00, status_q, cpl_dw_count, 3'b000, 13'd4,
                            6'd0, 2'b00, 1'b0, lower_addr};
            end
            StCpl1: begin
                cc_tkeep = cpl_sc ? 2'b11 : 2'b01;
                cc_tlast = 1'b1;
                cc_tdata = {(cpl_sc ? rd_data_q : 32'h0), 1'b0, attr_q, tc_q, 1'b0, 16'h0, tag_q};
            end
            default: ;
        endcase
    end

    assign axis.s_axis_cq_tready = cq_ready_q;
    assign axis.m_axis_cc_tdata  = cc_tdata;
    assign axis.m_axis_cc_tkeep  = cc_tkeep;
    assign axis.m_axis_cc_tlast  = cc_tlast;
    assign axis.m_axis_cc_tuser  = '0;
    assign axis.m_axis_cc_tvalid = cc_valid;

    // Credit is always granted; tready backpressure does the real flow control.
    assign pcie_cq_np_req = 1'b1;

    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_wr_strb = wr_strb_q;
    assign reg_rd_en   = (state_q == StRdIssue);
    assign reg_rd_addr = addr_q[REG_ADDR_WIDTH+1:2];

    logic unused_ok;
    assign unused_ok = ^{axis.s_axis_cq_tkeep, axis.s_axis_cq_tuser[84:4]};

`ifdef CQ_STATS_EN
    logic [15:0] stat_rd_q;
    logic [15:0] stat_wr_q;
    logic [15:0] stat_ur_q;
    logic        cpl_done;

    assign cpl_done = cc_fire && (state_q == StCpl1);

    // Saturating counters of accepted completions and register writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
            stat_ur_q <= '0;
        end else begin
            if (cpl_done && cpl_sc && (stat_rd_q != 16'hFFFF)) stat_rd_q <= stat_rd_q + 16'd1;
            if (cpl_done && !cpl_sc && (stat_ur_q != 16'hFFFF)) stat_ur_q <= stat_ur_q + 16'd1;
            if (wr_en_q && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
        end
    end

    assign stat_rd_count = stat_rd_q;
    assign stat_wr_count = stat_wr_q;
    assign stat_ur_count = stat_ur_q;
`endif

endmodule

// File: tb/tb_pcie_us_cq_reg_completer.sv
// Self-checking bench for pcie_us_cq_reg_completer: directed test-plan cases followed by
// randomized requests checked against a transaction-level model of the register completer.
module tb_pcie_us_cq_reg_completer;
    localparam int unsigned RegAw = 8;
    localparam int unsigned BarId = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcie_us_cq_reg_completer_if axis ();

    logic             np_req;
    logic             reg_wr_en;
    logic [RegAw-1:0] reg_wr_addr;
    logic [31:0]      reg_wr_data;
    logic [3:0]       reg_wr_strb;
    logic             reg_rd_en;
    logic [RegAw-1:0] reg_rd_addr;
    logic [31:0]      reg_rd_data = 32'h0;
`ifdef CQ_STATS_EN
    logic [15:0] stat_rd_count, stat_wr_count, stat_ur_count;
    int exp_st_rd = 0, exp_st_wr = 0, exp_st_ur = 0;
`endif

    pcie_us_cq_reg_completer #(
        .REG_ADDR_WIDTH(RegAw),
        .BAR_ID        (BarId)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axis          (axis.slave),
        .pcie_cq_np_req(np_req),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data)
`ifdef CQ_STATS_EN
        ,
        .stat_rd_count (stat_rd_count),
        .stat_wr_count (stat_wr_count),
        .stat_ur_count (stat_ur_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct packed {logic [63:0] d; logic [1:0] k; logic l;} beat_t;
    typedef struct packed {logic [7:0] a; logic [31:0] d; logic [3:0] s;} wr_t;

    logic [31:0] regs [256];
    beat_t       cc_obs[$];
    beat_t       cc_exp[$];
    wr_t         wr_obs[$];
    wr_t         wr_exp[$];
    logic [7:0]  rd_obs[$];
    logic [7:0]  rd_exp[$];
    int          bp_mode = 0;   // 0: cc_tready high, 1: random, 2: held low
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_a = 8'h0;

    // Core-side CC sink, register-port responder and monitors, all at the falling edge.
    always @(negedge clk) begin
        if (bp_mode == 0)      axis.m_axis_cc_tready = 1'b1;
        else if (bp_mode == 1) axis.m_axis_cc_tready = ($urandom_range(0, 2) != 0);
        else                   axis.m_axis_cc_tready = 1'b0;
        if (rst_n) begin
            // Read data is valid only in the cycle after the strobe; garbage otherwise.
            if (rd_pend) reg_rd_data = regs[rd_a];
            else         reg_rd_data = $urandom;
            rd_pend = 1'b0;
            if (reg_rd_en) begin
                rd_pend = 1'b1;
                rd_a    = reg_rd_addr;
                rd_obs.push_back(reg_rd_addr);
            end
            if (reg_wr_en) wr_obs.push_back({reg_wr_addr, reg_wr_data, reg_wr_strb});
            if (axis.m_axis_cc_tvalid && axis.m_axis_cc_tready)
                cc_obs.push_back({axis.m_axis_cc_tdata, axis.m_axis_cc_tkeep,
                                  axis.m_axis_cc_tlast});
            if (axis.m_axis_cc_tvalid) check_eq("cq_tready_in_cpl", axis.s_axis_cq_tready, 0);
        end else begin
            rd_pend = 1'b0;
        end
    end

    function automatic logic [1:0] first_bit(input logic [3:0] be);
        logic [1:0] r = 2'd0;
        for (int i = 3; i >= 0; i--) if (be[i]) r = 2'(i);
        return r;
    endfunction

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic cq_beat(input logic [63:0] d, input logic last, input logic [3:0] be);
        int   n = 0;
        logic ok;
        axis.s_axis_cq_tdata  = d;
        axis.s_axis_cq_tkeep  = 2'b11;
        axis.s_axis_cq_tlast  = last;
        axis.s_axis_cq_tuser  = {81'({$urandom(), $urandom(), $urandom()}), be};
        axis.s_axis_cq_tvalid = 1'b1;
        do begin
            ok = axis.s_axis_cq_tready;
            @(negedge clk);
            n++;
        end while (!ok && n < 100);
        check_eq("cq_beat_accepted", ok, 1);
    endtask

    task automatic exp_cpl(input logic [2:0] st, input logic [63:0] addr, input logic [3:0] be,
                           input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                           input logic [2:0] attr, input logic [31:0] data);
        logic [10:0] dwc = (st == 3'b000) ? 11'd1 : 11'd0;
        logic [6:0]  la  = {addr[6:2], first_bit(be)};
        cc_exp.push_back({{rid, 2'b00, st, dwc, 3'b000, 13'd4, 6'd0, 2'b00, 1'b0, la}, 2'b11, 1'b0});
        cc_exp.push_back({{data, 1'b0, attr, tc, 1'b0, 16'h0, tag},
                          (st == 3'b000) ? 2'b11 : 2'b01, 1'b1});
`ifdef CQ_STATS_EN
        if (st == 3'b000) exp_st_rd++;
        else              exp_st_ur++;
`endif
    endtask

    // Sends one request TLP and records what the register completer must do with it.
    task automatic do_req(input logic [3:0] typ, input logic [63:0] addr, input logic [10:0] dwc,
                          input logic [3:0] be, input logic [2:0] bar, input logic [7:0] tag,
                          input logic [15:0] rid, input logic [2:0] tc, input logic [2:0] attr,
                          input logic single, input logic desc_last, input int data_beats,
                          input logic [31:0] wdata);
        logic [63:0] b0 = {addr[63:2], 2'b00};
        logic [63:0] b1 = {1'b0, attr, tc, 6'($urandom), bar, 8'($urandom), tag, rid, 1'b0,
                           typ, dwc};
        logic        hit = (bar == 3'(BarId)) && (dwc == 11'd1) && (addr[63:RegAw+2] == '0);
        logic [7:0]  idx = addr[RegAw+1:2];
        if (single) begin
            cq_beat(b0, 1'b1, be);
        end else begin
            cq_beat(b0, 1'b0, be);
            cq_beat(b1, desc_last, be);
            if (!desc_last) begin
                if (typ == 4'd1) begin
                    for (int i = 0; i < data_beats; i++)
                        cq_beat({$urandom, wdata}, (i == data_beats - 1), be);
                    if (hit && data_beats == 1) begin
                        wr_exp.push_back({idx, wdata, be});
                        regs[idx] = wdata;
`ifdef CQ_STATS_EN
                        exp_st_wr++;
`endif
                    end
                end else begin
                    cq_beat({$urandom, $urandom}, 1'b1, be);
                end
            end else if (typ == 4'd0 && hit) begin
                rd_exp.push_back(idx);
                exp_cpl(3'b000, addr, be, rid, tag, tc, attr, regs[idx]);
            end else if (typ != 4'd1 && typ <= 4'd11) begin
                exp_cpl(3'b001, addr, be, rid, tag, tc, attr, 32'h0);
            end
        end
        axis.s_axis_cq_tvalid = 1'b0;
    endtask

    task automatic clear_q();
        cc_obs.delete(); cc_exp.delete(); wr_obs.delete(); wr_exp.delete();
        rd_obs.delete(); rd_exp.delete();
    endtask

    // Waits for outstanding completions, then scores everything observed against the model.
    task automatic settle();
        int n = 0;
        while (cc_obs.size() < cc_exp.size() && n < 80) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq("cc_beat_count", cc_obs.size(), cc_exp.size());
        for (int i = 0; i < cc_obs.size() && i < cc_exp.size(); i++) begin
            logic [63:0] m = (cc_exp[i].k == 2'b01) ? 64'hFFFF_FFFF : '1;
            check_eq("cc_tdata", cc_obs[i].d & m, cc_exp[i].d & m);
            check_eq("cc_tkeep", cc_obs[i].k, cc_exp[i].k);
            check_eq("cc_tlast", cc_obs[i].l, cc_exp[i].l);
        end
        check_eq("wr_count", wr_obs.size(), wr_exp.size());
        for (int i = 0; i < wr_obs.size() && i < wr_exp.size(); i++)
            check_eq("wr_addr_data_strb", wr_obs[i], wr_exp[i]);
        check_eq("rd_count", rd_obs.size(), rd_exp.size());
        for (int i = 0; i < rd_obs.size() && i < rd_exp.size(); i++)
            check_eq("rd_addr", rd_obs[i], rd_exp[i]);
        check_eq("cq_tready_idle", axis.s_axis_cq_tready, 1);
        clear_q();
    endtask

    initial begin
        logic [63:0] held;
        int          n;
        for (int i = 0; i < 256; i++) regs[i] = $urandom;
        axis.s_axis_cq_tdata  = '0;
        axis.s_axis_cq_tkeep  = '0;
        axis.s_axis_cq_tlast  = 1'b0;
        axis.s_axis_cq_tuser  = '0;
        axis.s_axis_cq_tvalid = 1'b0;
        axis.m_axis_cc_tready = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_cq_tready", axis.s_axis_cq_tready, 0);
        check_eq("rst_cc_tvalid", axis.m_axis_cc_tvalid, 0);
        check_eq("rst_cc_tdata", axis.m_axis_cc_tdata, 0);
        check_eq("rst_np_req", np_req, 1);
        check_eq("rst_wr_en", reg_wr_en, 0);
        check_eq("rst_rd_en", reg_rd_en, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MemRd of register 4.
        regs[4] = 32'hDEAD_BEEF;
        do_req(4'd0, 64'h10, 11'd1, 4'hF, 3'd0, 8'h2A, 16'h0100, 3'd0, 3'd0, 1'b0, 1'b1, 1, 0);
        settle();
        // MemWr of register 2 with partial strobes.
        do_req(4'd1, 64'h08, 11'd1, 4'h3, 3'd0, 8'h01, 16'h0100, 3'd0, 3'd0, 1'b0, 1'b0, 1,
               32'h1234_5678);
        settle();
        // MemRd with dword_count 2 completes UR.
        do_req(4'd0, 64'h20, 11'd2, 4'hF, 3'd0, 8'h05, 16'h0200, 3'd1, 3'd2, 1'b0, 1'b1, 1, 0);
        settle();
        // MemWr to BAR 1 is dropped.
        do_req(4'd1, 64'h08, 11'd1, 4'hF, 3'd1, 8'h06, 16'h0200, 3'd0, 3'd0, 1'b0, 1'b0, 1,
               32'hCAFE_F00D);
        settle();

        // Completion backpressure on beat 0.
        bp_mode = 2;
        do_req(4'd0, 64'h44, 11'd1, 4'hC, 3'd0, 8'h33, 16'hBEEF, 3'd2, 3'd1, 1'b0, 1'b1, 1, 0);
        n = 0;
        while (!axis.m_axis_cc_tvalid && n < 20) begin @(negedge clk); n++; end
        check_eq("bp_cc_tvalid", axis.m_axis_cc_tvalid, 1);
        held = axis.m_axis_cc_tdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_tdata_stable", axis.m_axis_cc_tdata, held);
            check_eq("bp_cq_tready", axis.s_axis_cq_tready, 0);
        end
        bp_mode = 0;
        settle();

        // Reset while the completion is stalled in beat 0.
        bp_mode = 2;
        do_req(4'd0, 64'h18, 11'd1, 4'hF, 3'd0, 8'h44, 16'h0300, 3'd0, 3'd0, 1'b0, 1'b1, 1, 0);
        n = 0;
        while (!axis.m_axis_cc_tvalid && n < 20) begin @(negedge clk); n++; end
        check_eq("rst_mid_cpl_pre", axis.m_axis_cc_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cpl_tvalid", axis.m_axis_cc_tvalid, 0);
        check_eq("rst_mid_cq_tready", axis.s_axis_cq_tready, 0);
        @(negedge clk);
        clear_q();
`ifdef CQ_STATS_EN
        exp_st_rd = 0; exp_st_wr = 0; exp_st_ur = 0;
`endif
        bp_mode = 0;
        rst_n = 1'b1;
        @(negedge clk);
        do_req(4'd0, 64'h18, 11'd1, 4'h2, 3'd0, 8'h45, 16'h0301, 3'd0, 3'd0, 1'b0, 1'b1, 1, 0);
        settle();

        // Randomized requests.
        for (int it = 0; it < 300; it++) begin
            int          r = $urandom_range(0, 9);
            logic [3:0]  typ;
            logic [63:0] addr = 64'($urandom_range(0, 255)) << 2;
            logic [10:0] dwc = ($urandom_range(0, 4) != 0) ? 11'd1 : 11'($urandom_range(0, 3));
            logic [2:0]  bar = ($urandom_range(0, 6) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
            logic        single = ($urandom_range(0, 19) == 0);
            logic        dlast;
            int          beats = ($urandom_range(0, 7) == 0) ? 2 : 1;
            if (r < 4)      typ = 4'd0;
            else if (r < 8) typ = 4'd1;
            else            typ = 4'($urandom_range(2, 15));
            if ($urandom_range(0, 5) == 0) addr[$urandom_range(RegAw + 2, 63)] = 1'b1;
            if (typ == 4'd0)      dlast = ($urandom_range(0, 9) != 0);
            else if (typ == 4'd1) dlast = ($urandom_range(0, 9) == 0);
            else                  dlast = $urandom_range(0, 1) != 0;
            bp_mode = it % 2;
            do_req(typ, addr, dwc, 4'($urandom), bar, 8'($urandom), 16'($urandom),
                   3'($urandom), 3'($urandom), single, dlast, beats, $urandom);
            settle();
        end
        bp_mode = 0;

`ifdef CQ_STATS_EN
        check_eq("stat_rd_count", stat_rd_count, exp_st_rd);
        check_eq("stat_wr_count", stat_wr_count, exp_st_wr);
        check_eq("stat_ur_count", stat_ur_count, exp_st_ur);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
